key_note_encoder: RTL
=====================

Name: key_note_encoder

Overview:
- Upstream front-end for the midi tone generator: replaces the raw combinational KEY1..KEY4 priority mux in the top level.
- Synchronises and debounces four active-low push-buttons, then priority-encodes them into an 8-bit MIDI note number.
- Drives midi.note_select, plus a one-cycle change strobe and a gate for downstream envelope/LED use.
- Runs on the board 50 MHz clock.

Parameters:
- P_DEB_CYCLES, 500000, stable cycles required before a key change is accepted. 10 ms at 50 MHz. Minimum 2.
- P_KEY_ACT, 1'b0, active level of raw key inputs.
- P_NOTE0, 8'd60, note for key 0 (highest priority).
- P_NOTE1, 8'd62, note for key 1.
- P_NOTE2, 8'd64, note for key 2.
- P_NOTE3, 8'd65, note for key 3 (lowest priority).

Ports:
- aclk  in  1  system clock, 50 MHz.
- areset  in  1  asynchronous active-high reset.
- en  in  1  clock enable; when 0 all state holds.
- i_keys  in  4  raw asynchronous key pins; bit0 = KEY1.
- o_keys_db  out  4  debounced key state, 1 = pressed, after polarity normalisation.
- o_note  out  8  current note, 0 = silence. Connects to midi.note_select.
- o_note_valid  out  1  one-cycle strobe when o_note changes.
- o_gate  out  1  1 while any debounced key is pressed.

Behaviour:
- Interface: single clock aclk. Reset areset is asynchronous, active-high. All flops clear on assertion; deassertion is used as-is, because the upstream reset is already synchronised.
- Reset values:
  - Synchroniser flops = inactive (~P_KEY_ACT).
  - Debounce counters = 0.
  - o_keys_db = 4'b0.
  - o_note = 8'd0.
  - o_note_valid = 0.
  - o_gate = 0.
  - FSM = S_IDLE.
- Per key:
  - 2-FF synchroniser, then normalise to pressed = (sync == P_KEY_ACT).
  - Counter width is $clog2(P_DEB_CYCLES).
  - If sync != stable: counter increments. When counter == P_DEB_CYCLES-1, stable <= sync and counter <= 0.
  - If sync == stable: counter <= 0, so any glitch shorter than P_DEB_CYCLES cycles is discarded.
  - Counter saturates at the accept point and never wraps.
- Latency (en=1), clean input edge:
  - o_keys_db changes exactly 2 + P_DEB_CYCLES cycles later.
  - o_note, o_note_valid and o_gate change 1 cycle after that.
- Encoder: next_note = note of the lowest-index pressed key, else 0. Registered.
- FSM states:
  - S_IDLE (no key pressed):
    - Any key pressed -> S_PLAY; o_note <= next_note; o_note_valid <= 1; o_gate <= 1.
  - S_PLAY:
    - No key pressed -> S_IDLE; o_note <= 0; o_note_valid <= 1; o_gate <= 0.
    - next_note != o_note -> stay in S_PLAY; o_note <= next_note; o_note_valid <= 1.
    - Otherwise hold; o_note_valid <= 0.
- Boundary cases:
  - o_note_valid is high for exactly one cycle per change, never two in a row for the same value.
  - Several keys accepted in the same cycle -> one strobe, lowest-index note.
  - A higher-index key pressed while a lower-index key is held -> no strobe, note unchanged.
  - Releasing the higher-priority key with others still held -> strobe to the next-priority note.
- en = 0: synchronisers still sample (metastability protection). Counters, stable bits, FSM and outputs hold. o_note_valid is forced 0 and resumes on the first en = 1 cycle.
- areset mid-debounce or mid-note: immediate return to reset values. After release the first note requires a full debounce period again; no strobe is emitted for reset itself.

Decomposition:
- Shared package midi_pkg:
  - Note constants NOTE_OFF = 8'd0, NOTE_C4 = 60, NOTE_D4 = 62, NOTE_E4 = 64, NOTE_F4 = 65.
  - FSM enum {S_IDLE, S_PLAY}.
  - Default debounce constant DEB_10MS_50MHZ = 500000.
- Sub-module key_debounce:
  - One bit, parameterised by P_DEB_CYCLES and P_KEY_ACT.
  - Contains the synchroniser and counter.
  - Instantiated four times via generate.
- The encoder and FSM stay in the parent.

Test Plan (P_DEB_CYCLES = 16, P_KEY_ACT = 0, en = 1 unless stated):
1. Reset: assert areset with keys = 4'b0000 (all pressed) -> all outputs 0 while asserted; release -> o_note = 60, strobe at cycle 2+16+1, o_gate = 1.
2. Glitch: drive KEY2 low for 10 cycles, then high -> o_keys_db stays 0, no strobe, o_note = 0.
3. Priority: press KEY3, then hold and press KEY1 -> o_note 64 then 60, one strobe each. Press KEY4 while KEY1 held -> no strobe. Release KEY1 -> o_note 64 with strobe.
4. Simultaneous: KEY2 and KEY4 pressed in the same cycle -> single strobe, o_note = 62. Release both together -> single strobe, o_note = 0, o_gate = 0.
5. Enable: press KEY1, drop en at cycle 10 of the debounce for 20 cycles -> o_note changes only after a total of 16 enabled counting cycles. No strobe while en = 0.
6. Reset mid-note: while o_note = 65, pulse areset for 1 cycle with KEY4 still pressed -> o_note = 0 immediately; o_note = 65 returns 2+16+1 cycles after release, with one strobe.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared constants and types for the key-to-note front-end.
// Note numbers, debounce default and encoder FSM states.
package midi_pkg;

   localparam logic [7:0] NOTE_OFF = 8'd0;
   localparam logic [7:0] NOTE_C4  = 8'd60;
   localparam logic [7:0] NOTE_D4  = 8'd62;
   localparam logic [7:0] NOTE_E4  = 8'd64;
   localparam logic [7:0] NOTE_F4  = 8'd65;

   // 10 ms of stable input at 50 MHz
   localparam int DEB_10MS_50MHZ = 500000;

   typedef enum logic {
      S_IDLE,
      S_PLAY
   } state_t;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, polarity normalisation and
// stability counter; key_db is 1 while the key is held.
module key_debounce
   import midi_pkg::*;
#(
   parameter int   P_DEB_CYCLES = DEB_10MS_50MHZ,
   parameter logic P_KEY_ACT    = 1'b0
) (
   input  logic aclk,
   input  logic areset,
   input  logic en,
   input  logic key_raw,
   output logic key_db
);

   localparam int CW = $clog2(P_DEB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(P_DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt;
   logic          pressed;

   assign pressed = (sync_q[1] == P_KEY_ACT);

   // synchroniser samples every cycle, even with en low
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         sync_q <= {2{~P_KEY_ACT}};
      end else begin
         sync_q <= {sync_q[0], key_raw};
      end
   end

   // accept a new level only after it held for P_DEB_CYCLES
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cnt    <= '0;
         key_db <= 1'b0;
      end else if (en) begin
         if (pressed != key_db) begin
            if (cnt == LAST) begin
               key_db <= pressed;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/key_note_encoder.sv
// Debounced four-key priority encoder feeding the tone
// generator note select, with change strobe and gate.
module key_note_encoder
   import midi_pkg::*;
#(
   parameter int         P_DEB_CYCLES = DEB_10MS_50MHZ,
   parameter logic       P_KEY_ACT    = 1'b0,
   parameter logic [7:0] P_NOTE0      = NOTE_C4,
   parameter logic [7:0] P_NOTE1      = NOTE_D4,
   parameter logic [7:0] P_NOTE2      = NOTE_E4,
   parameter logic [7:0] P_NOTE3      = NOTE_F4
) (
   input  logic       aclk,
   input  logic       areset,
   input  logic       en,
   input  logic [3:0] i_keys,
   output logic [3:0] o_keys_db,
   output logic [7:0] o_note,
   output logic       o_note_valid,
   output logic       o_gate
);

   state_t     state;
   logic [7:0] next_note;

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(
         .P_DEB_CYCLES (P_DEB_CYCLES),
         .P_KEY_ACT    (P_KEY_ACT)
      ) u_deb (
         .aclk    (aclk),
         .areset  (areset),
         .en      (en),
         .key_raw (i_keys[i]),
         .key_db  (o_keys_db[i])
      );
   end

   // lowest-index held key wins
   always_comb begin
      next_note = NOTE_OFF;
      if (o_keys_db[0])      next_note = P_NOTE0;
      else if (o_keys_db[1]) next_note = P_NOTE1;
      else if (o_keys_db[2]) next_note = P_NOTE2;
      else if (o_keys_db[3]) next_note = P_NOTE3;
   end

   // note FSM with registered outputs; strobe only on change
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state        <= S_IDLE;
         o_note       <= NOTE_OFF;
         o_note_valid <= 1'b0;
         o_gate       <= 1'b0;
      end else if (en) begin
         unique case (state)
            S_IDLE: begin
               if (|o_keys_db) begin
                  state        <= S_PLAY;
                  o_note       <= next_note;
                  o_note_valid <= 1'b1;
                  o_gate       <= 1'b1;
               end else begin
                  o_note_valid <= 1'b0;
               end
            end
            S_PLAY: begin
               if (~|o_keys_db) begin
                  state        <= S_IDLE;
                  o_note       <= NOTE_OFF;
                  o_note_valid <= 1'b1;
                  o_gate       <= 1'b0;
               end else if (next_note != o_note) begin
                  o_note       <= next_note;
                  o_note_valid <= 1'b1;
               end else begin
                  o_note_valid <= 1'b0;
               end
            end
            default: begin
               state        <= S_IDLE;
               o_note_valid <= 1'b0;
            end
         endcase
      end else begin
         o_note_valid <= 1'b0;
      end
   end

endmodule
